multi_cycle_ctrl: RTL

Multi-cycle control unit for the multi_cpu datapath. It sequences each instruction through IF/ID/EXE/MEM/WB states and drives every datapath enable: the instruction register write enable (IRWre), PC write, register file write, data memory strobes and mux selects. Its opcode input comes from the instruction register output. The ALU Zero flag feeds back for branch resolution.

---
 rtl/multi_cpu_pkg.sv | 52 +++++
 rtl/ctrl_decode.sv | 112 +++++++++++
 rtl/multi_cycle_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/multi_cpu_pkg.sv
// multi_cpu_pkg: shared definitions for the multi_cpu control path.
// Holds the controller state encodings, the instruction opcodes, the ALU
// operation codes and the PC source select codes, plus small opcode
// classification helpers used by both the sequencer and the decoder.
package multi_cpu_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_WB_AL  = 4'b0011,
        S_EXE_BR = 4'b0100,
        S_EXE_LS = 4'b0101,
        S_MEM    = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_OR    = 6'b010001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_alu(input logic [5:0] op);
        return is_rtype(op) || (op == OP_ADDIU) || (op == OP_ORI);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational decode of (state, opcode, Zero) into every
// datapath enable and mux select. Moore-style: outputs depend on the current
// state and the held IR opcode only; Zero matters only in EXE_BR.
// Ports:
//   state   in  current controller state
//   opcode  in  IR[31:26]
//   Zero    in  ALU zero flag
//   PCWre, IRWre, InsMemRW, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
//   mRD, mWR, DBDataSrc, PCSrc  out  datapath controls
import multi_cpu_pkg::*;

module ctrl_decode (
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        Zero,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        RegWre,
    output logic        RegDst,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic [2:0]  ALUOp,
    output logic        mRD,
    output logic        mWR,
    output logic        DBDataSrc,
    output logic [1:0]  PCSrc
);

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = PC_NEXT;

        case (state)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            S_ID: begin
                // j and undefined opcodes complete here; everything else
                // writes the PC in a later state.
                if (opcode == OP_J) begin
                    PCWre = 1'b1;
                    PCSrc = PC_JUMP;
                end else if (!is_alu(opcode) && !is_mem(opcode) &&
                             opcode != OP_BEQ && opcode != OP_HALT) begin
                    PCWre = 1'b1;
                end
            end
            S_EXE_AL, S_WB_AL: begin
                // ALU controls are identical in both states so the result
                // stays stable while it is written back.
                RegDst = is_rtype(opcode);
                case (opcode)
                    OP_SUB:   ALUOp = ALU_SUB;
                    OP_AND:   ALUOp = ALU_AND;
                    OP_OR:    ALUOp = ALU_OR;
                    OP_ADDIU: begin
                        ALUSrcB = 1'b1;
                        ExtSel  = 1'b1;
                    end
                    OP_ORI: begin
                        ALUOp   = ALU_OR;
                        ALUSrcB = 1'b1;
                    end
                    default:  ALUOp = ALU_ADD;
                endcase
                if (state == S_WB_AL) begin
                    RegWre = 1'b1;
                    PCWre  = 1'b1;
                end
            end
            S_EXE_LS, S_MEM, S_WB_LD: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (state == S_MEM) begin
                    if (opcode == OP_LW) begin
                        mRD = 1'b1;
                    end else begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end else if (state == S_WB_LD) begin
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                    RegWre    = 1'b1;
                    PCWre     = 1'b1;
                end
            end
            S_EXE_BR: begin
                ALUOp  = ALU_SUB;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                PCSrc  = Zero ? PC_BRANCH : PC_NEXT;
            end
            default: begin
                // HALT: everything low so PC and IR freeze.
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: instruction sequencer for the multi_cpu datapath.
// Steps each instruction through IF/ID/EXE/MEM/WB and drives the datapath
// controls through ctrl_decode.
// Ports:
//   CLK, RST (async, active-low)  clock / reset
//   opcode  in  IR[31:26]; Zero in  ALU zero flag
//   PCWre..PCSrc  out  datapath controls (see ctrl_decode)
//   state   out  current state, for debug
import multi_cpu_pkg::*;

module multi_cycle_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic        Zero,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        RegWre,
    output logic        RegDst,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic [2:0]  ALUOp,
    output logic        mRD,
    output logic        mWR,
    output logic        DBDataSrc,
    output logic [1:0]  PCSrc,
    output logic [3:0]  state
);

    state_t cur_state;
    state_t next_state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_state <= S_IF;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = S_IF;
        case (cur_state)
            S_IF: next_state = S_ID;
            S_ID: begin
                if (is_alu(opcode))        next_state = S_EXE_AL;
                else if (is_mem(opcode))   next_state = S_EXE_LS;
                else if (opcode == OP_BEQ) next_state = S_EXE_BR;
                else if (opcode == OP_HALT) next_state = S_HALT;
                else                       next_state = S_IF;  // j or undefined
            end
            S_EXE_AL: next_state = S_WB_AL;
            S_EXE_LS: next_state = S_MEM;
            S_MEM:    next_state = (opcode == OP_LW) ? S_WB_LD : S_IF;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IF;  // WB_AL, WB_LD, EXE_BR, illegal codes
        endcase
    end

    assign state = cur_state;

    ctrl_decode u_decode (
        .state     (cur_state),
        .opcode    (opcode),
        .Zero      (Zero),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUOp     (ALUOp),
        .mRD       (mRD),
        .mWR       (mWR),
        .DBDataSrc (DBDataSrc),
        .PCSrc     (PCSrc)
    );

endmodule
